multicycle_controller: RTL

Multi-cycle control unit for the Yu Core datapath. It sequences each RV32I instruction through fetch, decode, execute, memory and writeback states. For each state it drives every datapath enable, mux select and ALU operation, and it stalls on a ready handshake from the shared instruction/data memory. It also keeps a retired-instruction counter and halts permanently on an unsupported encoding.

---
 rtl/multicycle_controller_if.sv | 38 +++
 rtl/multicycle_controller.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multicycle controller and the Yu Core datapath.
interface multicycle_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            f7b5;
  logic            aluZero;
  logic            memReady;
  logic            memReadEnable;
  logic            memWriteEnable;
  logic            memAddrSrc;
  logic            irWriteEnable;
  logic            pcWriteEnable;
  logic [1:0]      pcSrc;
  logic            regWriteEnable;
  logic [1:0]      resultSrc;
  logic            aluSrcB;
  logic [3:0]      aluControl;
  logic            halted;
  logic [XLEN-1:0] instret;

  // Controller side: consumes instruction fields and status, drives controls.
  modport master (
    input  opcode, f3, f7b5, aluZero, memReady,
    output memReadEnable, memWriteEnable, memAddrSrc, irWriteEnable,
           pcWriteEnable, pcSrc, regWriteEnable, resultSrc, aluSrcB,
           aluControl, halted, instret
  );

  // Datapath/memory side.
  modport slave (
    output opcode, f3, f7b5, aluZero, memReady,
    input  memReadEnable, memWriteEnable, memAddrSrc, irWriteEnable,
           pcWriteEnable, pcSrc, regWriteEnable, resultSrc, aluSrcB,
           aluControl, halted, instret
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: sequences fetch/decode/execute/memory/writeback,
// stalls on memReady, counts retired instructions and halts on illegal encodings.
module multicycle_controller #(
  parameter int unsigned XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  multicycle_controller_if.master bus
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_REG    = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLT  = 4'd5;
  localparam logic [3:0] ALU_SLTU = 4'd6;
  localparam logic [3:0] ALU_SLL  = 4'd7;
  localparam logic [3:0] ALU_SRL  = 4'd8;
  localparam logic [3:0] ALU_SRA  = 4'd9;

  typedef enum logic [2:0] {
    S_START     = 3'd0,
    S_FETCH     = 3'd1,
    S_DECODE    = 3'd2,
    S_EXECUTE   = 3'd3,
    S_MEMORY    = 3'd4,
    S_WRITEBACK = 3'd5,
    S_HALT      = 3'd6
  } state_t;

  state_t          state;
  logic [6:0]      op_q;
  logic [2:0]      f3_q;
  logic            f7b5_q;
  logic [XLEN-1:0] instret_q;
  logic            retire_c;

  // Legal encodings of the supported RV32I subset.
  function automatic logic is_legal(input logic [6:0] op, input logic [2:0] fn3);
    case (op)
      OPC_LOAD, OPC_STORE:                 return fn3 == 3'b010;
      OPC_IMM, OPC_REG, OPC_JAL, OPC_LUI:  return 1'b1;
      OPC_BRANCH:                          return fn3[2:1] == 2'b00;
      default:                             return 1'b0;
    endcase
  endfunction

  // funct3 to ALU operation; alt (instr[30]) picks SUB only for register ops.
  function automatic logic [3:0] alu_map(input logic [2:0] fn3, input logic alt,
                                         input logic is_reg);
    case (fn3)
      3'b000:  return (is_reg && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic is_load, is_store, is_imm, is_reg, is_branch, is_jal, is_lui;
  assign is_load   = (op_q == OPC_LOAD);
  assign is_store  = (op_q == OPC_STORE);
  assign is_imm    = (op_q == OPC_IMM);
  assign is_reg    = (op_q == OPC_REG);
  assign is_branch = (op_q == OPC_BRANCH);
  assign is_jal    = (op_q == OPC_JAL);
  assign is_lui    = (op_q == OPC_LUI);

  // State sequencing, instruction field latch and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_START;
      op_q      <= '0;
      f3_q      <= '0;
      f7b5_q    <= 1'b0;
      instret_q <= '0;
    end else begin
      case (state)
        S_START:   state <= S_FETCH;
        S_FETCH:   if (bus.memReady) state <= S_DECODE;
        S_DECODE: begin
          op_q   <= bus.opcode;
          f3_q   <= bus.f3;
          f7b5_q <= bus.f7b5;
          state  <= is_legal(bus.opcode, bus.f3) ? S_EXECUTE : S_HALT;
        end
        S_EXECUTE: begin
          if (is_load || is_store)       state <= S_MEMORY;
          else if (is_branch || is_jal)  state <= S_FETCH;
          else                           state <= S_WRITEBACK;
        end
        S_MEMORY:    if (bus.memReady) state <= is_load ? S_WRITEBACK : S_FETCH;
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_START;
      endcase
      if (retire_c) instret_q <= instret_q + XLEN'(1);
    end
  end

  assign bus.instret = instret_q;

  // Control decode from state and latched fields; memReady/aluZero feed through where needed.
  always_comb begin
    bus.memReadEnable  = 1'b0;
    bus.memWriteEnable = 1'b0;
    bus.memAddrSrc     = 1'b0;
    bus.irWriteEnable  = 1'b0;
    bus.pcWriteEnable  = 1'b0;
    bus.pcSrc          = 2'd0;
    bus.regWriteEnable = 1'b0;
    bus.resultSrc      = 2'd0;
    bus.aluSrcB        = 1'b0;
    bus.aluControl     = ALU_ADD;
    bus.halted         = 1'b0;
    retire_c           = 1'b0;
    case (state)
      S_FETCH: begin
        bus.memReadEnable = 1'b1;
        bus.irWriteEnable = bus.memReady;
        bus.pcWriteEnable = bus.memReady;
      end
      S_EXECUTE: begin
        if (is_reg) begin
          bus.aluControl = alu_map(f3_q, f7b5_q, 1'b1);
        end else if (is_imm) begin
          bus.aluSrcB    = 1'b1;
          bus.aluControl = alu_map(f3_q, f7b5_q, 1'b0);
        end else if (is_load || is_store) begin
          bus.aluSrcB = 1'b1;
        end else if (is_branch) begin
          bus.aluControl    = ALU_SUB;
          bus.pcSrc         = 2'd1;
          bus.pcWriteEnable = bus.aluZero ^ f3_q[0];
          retire_c          = 1'b1;
        end else if (is_jal) begin
          bus.pcWriteEnable  = 1'b1;
          bus.pcSrc          = 2'd1;
          bus.regWriteEnable = 1'b1;
          bus.resultSrc      = 2'd2;
          retire_c           = 1'b1;
        end
      end
      S_MEMORY: begin
        bus.memAddrSrc     = 1'b1;
        bus.aluSrcB        = 1'b1;
        bus.memReadEnable  = is_load;
        bus.memWriteEnable = is_store;
        retire_c           = is_store && bus.memReady;
      end
      S_WRITEBACK: begin
        bus.regWriteEnable = 1'b1;
        retire_c           = 1'b1;
        if (is_load)      bus.resultSrc = 2'd1;
        else if (is_lui)  bus.resultSrc = 2'd3;
        if (is_reg) begin
          bus.aluControl = alu_map(f3_q, f7b5_q, 1'b1);
        end else if (is_imm) begin
          bus.aluSrcB    = 1'b1;
          bus.aluControl = alu_map(f3_q, f7b5_q, 1'b0);
        end
      end
      S_HALT:  bus.halted = 1'b1;
      default: ;
    endcase
  end

endmodule
